cnn_bias_buffer: RTL and testbench
==================================

CNN_BIAS_BUFFER -- requirements
Module: cnn_bias_buffer

Interface
REQ-001 Parameter DATA_W, default 16: bias word width in bits.
REQ-002 Parameter DEPTH, default 64: bias entries per bank; legal range 2..1024, any value.
REQ-003 Parameter RD_PORTS, default 4: independent read channels.
REQ-004 Derived constant ADDR_W = clog2(DEPTH): address width.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 load_start  input  1  begin a burst load into the shadow bank.
REQ-008 load_base  input  ADDR_W  first shadow address of the burst, sampled with load_start.
REQ-009 load_len  input  ADDR_W+1  word count of the burst, sampled with load_start.
REQ-010 wr_valid  input  1  wr_data is valid.
REQ-011 wr_data  input  DATA_W  bias word to store.
REQ-012 wr_ready  output  1  the block accepts a write word this cycle.
REQ-013 load_busy  output  1  a burst load is in progress.
REQ-014 load_done  output  1  one-cycle pulse when a burst load completes.
REQ-015 bank_swap  input  1  request to exchange the active and shadow banks.
REQ-016 active_bank  output  1  index of the bank that serves reads.
REQ-017 rd_en  input  RD_PORTS  per-port read request.
REQ-018 rd_addr  input  RD_PORTS*ADDR_W  per-port address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-019 rd_data  output  RD_PORTS*DATA_W  per-port read data, packed the same way as rd_addr.
REQ-020 rd_valid  output  RD_PORTS  per-port data-valid flag.
REQ-021 addr_err  output  1  sticky out-of-range read flag.

Function
REQ-022 Storage SHALL be two banks of DEPTH x DATA_W words; writes SHALL go only to the shadow bank (bank index !active_bank), and reads SHALL come only from the active bank.
REQ-023 The load FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-024 In IDLE, a load_start with load_len != 0 SHALL latch the write pointer to load_base and the remaining count to load_len, then enter LOAD.
REQ-025 A load_start with load_len == 0 SHALL enter DONE directly, write nothing and produce a load_done pulse.
REQ-026 In LOAD, wr_ready=1 and load_busy=1.
REQ-027 In LOAD, each cycle with wr_valid&&wr_ready SHALL write wr_data to shadow[ptr], increment ptr, and decrement the remaining count.
REQ-028 On increment, ptr SHALL wrap from DEPTH-1 to 0.
REQ-029 The write that brings the remaining count to 0 SHALL move the FSM to DONE on the next edge.
REQ-030 A wr_valid deassertion in LOAD SHALL stall the FSM with no write and no timeout.
REQ-031 In DONE, load_done=1 for exactly one cycle and wr_ready=0, after which the FSM SHALL return to IDLE.
REQ-032 load_start outside IDLE SHALL be ignored.
REQ-033 wr_valid outside LOAD SHALL be ignored; wr_ready=0 outside LOAD.
REQ-034 A bank_swap in IDLE SHALL toggle active_bank on that edge.
REQ-035 A bank_swap in LOAD or DONE SHALL set a pending flag.
REQ-036 A pending swap SHALL execute on the edge leaving DONE and then clear; repeated requests while pending SHALL collapse into one swap.
REQ-037 bank_swap together with load_start in IDLE SHALL swap first, so the new load targets the post-swap shadow bank.
REQ-038 Per port p, rd_en[p]=1 with rd_addr_p < DEPTH SHALL register active[rd_addr_p] into rd_data_p and set rd_valid[p]=1 on the next cycle (1-cycle latency).
REQ-039 rd_en[p]=1 with rd_addr_p >= DEPTH (possible only for non-power-of-2 DEPTH) SHALL return rd_data_p=0 and rd_valid[p]=1 next cycle, and SHALL set addr_err.
REQ-040 addr_err SHALL stay set until reset.
REQ-041 rd_en[p]=0 SHALL give rd_valid[p]=0 next cycle, with rd_data_p holding its last value.
REQ-042 A read sampled in the same cycle as a swap SHALL return data from the pre-swap active bank.
REQ-043 Ports SHALL be fully independent; identical addresses on several ports SHALL all return the same word.

Reset
REQ-044 Assertion of rst SHALL immediately clear all of the following: both banks, FSM to IDLE, ptr, remaining count, pending swap, active_bank, rd_data, rd_valid, addr_err, wr_ready, load_busy and load_done.
REQ-045 Reset asserted mid-load SHALL abort the burst with no load_done pulse.

Structure
REQ-046 A shared package cnn_pkg SHALL hold the FSM state enum bias_load_state_t and the DATA_W default constant.
REQ-047 A single sub-module cnn_bias_rd_port SHALL implement one registered read port (range check, zero fill, valid) and SHALL be instantiated RD_PORTS times by generate.

Verification
REQ-048 Reset, then load_start, base=0, len=10, 10 consecutive valid words 0x0001..0x000A, then bank_swap -> load_done pulses one cycle after the 10th write, and port 0 reading address 9 returns 0x000A one cycle after rd_en.
REQ-049 Load base=62, len=4 with DEPTH=64 -> writes land at shadow addresses 62, 63, 0, 1.
REQ-050 bank_swap asserted during LOAD -> active_bank toggles only on the edge after the load_done cycle, and reads before that edge return old-bank data.
REQ-051 wr_valid gaps of 3 idle cycles inside a len=5 burst -> exactly 5 writes, and load_done is delayed by the idle cycles.
REQ-052 DEPTH=10: port 2 reads address 12 -> rd_data=0, rd_valid=1, addr_err=1 and stays 1; an in-range read on port 1 in the same cycle is unaffected.
REQ-053 rst pulsed after 3 of 8 words -> load_done never pulses, all outputs read 0, active_bank=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the CNN bias buffer slice.
//   BIAS_DATA_W       - default bias word width
//   bias_load_state_t - burst load FSM state encoding
package cnn_pkg;

    localparam int BIAS_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } bias_load_state_t;

endpackage

// File: rtl/cnn_bias_rd_port.sv
// cnn_bias_rd_port: one registered read channel of the bias buffer.
//   clk, rst   - clock, asynchronous active-high reset
//   rd_en      - read request
//   rd_addr    - requested address (may exceed DEPTH-1 when DEPTH is not 2^n)
//   mem_addr   - range-clamped address presented to the active bank
//   mem_word   - word read from the active bank at mem_addr
//   rd_data    - registered read data (holds when rd_en is low)
//   rd_valid   - registered copy of rd_en
//   addr_err   - sticky flag, set by any out-of-range request
module cnn_bias_rd_port #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_word,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic in_range;

    assign in_range = ({1'b0, rd_addr} < DEPTH_L);
    // Keep the bank index legal; the fetched word is discarded when out of range.
    assign mem_addr = in_range ? rd_addr : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= in_range ? mem_word : '0;
                if (!in_range) begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cnn_bias_buffer.sv
// cnn_bias_buffer: double-banked bias store with burst loader and
// RD_PORTS independent registered read ports.
//   clk, rst                     - clock, asynchronous active-high reset
//   load_start/load_base/load_len - start a burst load into the shadow bank
//   wr_valid/wr_data/wr_ready    - write word stream for the burst
//   load_busy/load_done          - burst in progress / one-cycle completion pulse
//   bank_swap/active_bank        - exchange banks / bank currently serving reads
//   rd_en/rd_addr/rd_data/rd_valid - packed per-port read channels, 1-cycle latency
//   addr_err                     - sticky out-of-range read flag
module cnn_bias_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_W   = BIAS_DATA_W,
    parameter int DEPTH    = 64,
    parameter int RD_PORTS = 4,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic [ADDR_W-1:0]          load_base,
    input  logic [ADDR_W:0]            load_len,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    output logic                       load_busy,
    output logic                       load_done,
    input  logic                       bank_swap,
    output logic                       active_bank,
    input  logic [RD_PORTS-1:0]        rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS*DATA_W-1:0] rd_data,
    output logic [RD_PORTS-1:0]        rd_valid,
    output logic                       addr_err
);

    bias_load_state_t  state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W:0]   remain_reg;
    logic              pending_reg;
    logic              active_reg;
    logic              wr_fire;

    logic [DATA_W-1:0] bank_mem [2][DEPTH];

    logic [ADDR_W-1:0] mem_addr [RD_PORTS];
    logic [DATA_W-1:0] mem_word [RD_PORTS];
    logic [RD_PORTS-1:0] err_vec;

    assign wr_ready    = (state_reg == ST_LOAD);
    assign load_busy   = (state_reg == ST_LOAD);
    assign load_done   = (state_reg == ST_DONE);
    assign active_bank = active_reg;
    assign wr_fire     = (state_reg == ST_LOAD) && wr_valid;
    assign ptr_next    = (ptr_reg == ADDR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
    assign addr_err    = |err_vec;

    // Load FSM and bank selection. Swaps requested while a burst is in
    // flight are deferred so the loader never changes target mid-burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            remain_reg  <= '0;
            pending_reg <= 1'b0;
            active_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Swap and start on the same edge: the burst writes the
                    // post-swap shadow, since writes use active_reg from LOAD on.
                    if (bank_swap) begin
                        active_reg <= ~active_reg;
                    end
                    if (load_start) begin
                        if (load_len != '0) begin
                            ptr_reg    <= load_base;
                            remain_reg <= load_len;
                            state_reg  <= ST_LOAD;
                        end else begin
                            state_reg  <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bank_swap) begin
                        pending_reg <= 1'b1;
                    end
                    if (wr_valid) begin
                        ptr_reg    <= ptr_next;
                        remain_reg <= remain_reg - 1'b1;
                        if (remain_reg == (ADDR_W + 1)'(1)) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // A request arriving in DONE merges with any pending one.
                    if (pending_reg || bank_swap) begin
                        active_reg <= ~active_reg;
                    end
                    pending_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Both banks are cleared by reset, so storage is register based.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    bank_mem[b][a] <= '0;
                end
            end
        end else if (wr_fire) begin
            bank_mem[~active_reg][ptr_reg] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd_port
            assign mem_word[gi] = bank_mem[active_reg][mem_addr[gi]];

            cnn_bias_rd_port #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .ADDR_W (ADDR_W)
            ) u_rd_port (
                .clk      (clk),
                .rst      (rst),
                .rd_en    (rd_en[gi]),
                .rd_addr  (rd_addr[gi*ADDR_W +: ADDR_W]),
                .mem_addr (mem_addr[gi]),
                .mem_word (mem_word[gi]),
                .rd_data  (rd_data[gi*DATA_W +: DATA_W]),
                .rd_valid (rd_valid[gi]),
                .addr_err (err_vec[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_cnn_bias_buffer.sv
// Directed bench for cnn_bias_buffer: a DEPTH=64 instance carries most
// scenarios through a read scoreboard, a DEPTH=10 instance covers
// out-of-range reads.
module tb_cnn_bias_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DEPTH=64 instance
    logic        load_start;
    logic [5:0]  load_base;
    logic [6:0]  load_len;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready, load_busy, load_done;
    logic        bank_swap, active_bank;
    logic [3:0]  rd_en;
    logic [23:0] rd_addr;
    logic [63:0] rd_data;
    logic [3:0]  rd_valid;
    logic        addr_err;

    // DEPTH=10 instance
    logic        t_load_start;
    logic [3:0]  t_load_base;
    logic [4:0]  t_load_len;
    logic        t_wr_valid;
    logic [15:0] t_wr_data;
    logic        t_wr_ready, t_load_busy, t_load_done;
    logic        t_bank_swap, t_active_bank;
    logic [3:0]  t_rd_en;
    logic [15:0] t_rd_addr;
    logic [63:0] t_rd_data;
    logic [3:0]  t_rd_valid;
    logic        t_addr_err;

    cnn_bias_buffer #(.DATA_W(16), .DEPTH(64), .RD_PORTS(4)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .load_busy(load_busy), .load_done(load_done),
        .bank_swap(bank_swap), .active_bank(active_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .addr_err(addr_err)
    );

    cnn_bias_buffer #(.DATA_W(16), .DEPTH(10), .RD_PORTS(4)) dut10 (
        .clk(clk), .rst(rst),
        .load_start(t_load_start), .load_base(t_load_base), .load_len(t_load_len),
        .wr_valid(t_wr_valid), .wr_data(t_wr_data), .wr_ready(t_wr_ready),
        .load_busy(t_load_busy), .load_done(t_load_done),
        .bank_swap(t_bank_swap), .active_bank(t_active_bank),
        .rd_en(t_rd_en), .rd_addr(t_rd_addr), .rd_data(t_rd_data),
        .rd_valid(t_rd_valid), .addr_err(t_addr_err)
    );

    typedef struct {
        int          port;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_mem [2][64];
    int          act_m;
    int          ptr_m;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance one cycle, drop one-shot inputs, then score pending reads.
    task automatic tick();
        logic [3:0] mask;
        exp_t       e;
        mask = '0;
        @(posedge clk);
        #1;
        load_start = 1'b0; bank_swap = 1'b0; rd_en = '0; wr_valid = 1'b0;
        t_load_start = 1'b0; t_bank_swap = 1'b0; t_rd_en = '0; t_wr_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mask[e.port] = 1'b1;
            check($sformatf("rd_data p%0d", e.port), 32'(rd_data[e.port*16 +: 16]), 32'(e.data));
        end
        check("rd_valid", 32'(rd_valid), 32'(mask));
    endtask

    task automatic rd_issue(input int p, input int a);
        exp_t e;
        rd_en[p] = 1'b1;
        rd_addr[p*6 +: 6] = 6'(a);
        e.port = p;
        e.data = model_mem[act_m][a];
        exp_q.push_back(e);
    endtask

    task automatic start_load(input int base, input int len);
        load_start = 1'b1;
        load_base  = 6'(base);
        load_len   = 7'(len);
        ptr_m      = base;
        tick();
    endtask

    task automatic write_word(input logic [15:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        model_mem[1 - act_m][ptr_m] = d;
        ptr_m = (ptr_m + 1) % 64;
        tick();
    endtask

    task automatic clear_model();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 64; a++)
                model_mem[b][a] = '0;
        act_m = 0;
    endtask

    initial begin
        rst = 1'b1;
        load_start = 0; load_base = 0; load_len = 0; wr_valid = 0; wr_data = 0;
        bank_swap = 0; rd_en = 0; rd_addr = 0;
        t_load_start = 0; t_load_base = 0; t_load_len = 0; t_wr_valid = 0; t_wr_data = 0;
        t_bank_swap = 0; t_rd_en = 0; t_rd_addr = 0;
        clear_model();
        ptr_m = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst wr_ready", 32'(wr_ready), 0);
        check("rst load_busy", 32'(load_busy), 0);
        check("rst load_done", 32'(load_done), 0);
        check("rst active_bank", 32'(active_bank), 0);
        check("rst rd_valid", 32'(rd_valid), 0);
        check("rst rd_data", rd_data[31:0], 0);
        check("rst addr_err", 32'(addr_err), 0);
        rst = 1'b0;
        tick();
        rd_issue(0, 5);
        tick();

        // Base 0, len 10, words 1..10, then swap and read back
        start_load(0, 10);
        check("load_busy in LOAD", 32'(load_busy), 1);
        check("wr_ready in LOAD", 32'(wr_ready), 1);
        for (int i = 1; i <= 10; i++) begin
            write_word(16'(i));
            if (i < 10) check("load_done early", 32'(load_done), 0);
        end
        check("load_done pulse", 32'(load_done), 1);
        check("wr_ready in DONE", 32'(wr_ready), 0);
        check("load_busy in DONE", 32'(load_busy), 0);
        tick();
        check("load_done one cycle", 32'(load_done), 0);
        bank_swap = 1'b1;
        tick();
        act_m = 1;
        check("swap in IDLE", 32'(active_bank), 1);
        rd_issue(0, 9);
        tick();
        for (int p = 0; p < 4; p++) rd_issue(p, 3);
        tick();

        // Wrapping burst: base 62, len 4
        start_load(62, 4);
        for (int i = 0; i < 4; i++) write_word(16'h0100 + 16'(i));
        check("wrap load_done", 32'(load_done), 1);
        tick();
        bank_swap = 1'b1;
        tick();
        act_m = 0;
        check("swap back", 32'(active_bank), 0);
        rd_issue(0, 62); rd_issue(1, 63); rd_issue(2, 0); rd_issue(3, 1);
        tick();
        rd_issue(0, 2); rd_issue(1, 61);
        tick();

        // Swap requested during LOAD is deferred to the edge leaving DONE
        start_load(20, 3);
        bank_swap = 1'b1;
        write_word(16'h0200);
        check("deferred swap 1", 32'(active_bank), 0);
        bank_swap = 1'b1;
        rd_issue(0, 62);
        write_word(16'h0201);
        check("deferred swap 2", 32'(active_bank), 0);
        write_word(16'h0202);
        check("deferred load_done", 32'(load_done), 1);
        check("no swap in DONE", 32'(active_bank), 0);
        rd_issue(1, 62);
        tick();
        check("swap after DONE", 32'(active_bank), 1);
        act_m = 1;
        rd_issue(3, 20); rd_issue(2, 22);
        tick();
        check("single swap", 32'(active_bank), 1);

        // Zero-length load
        load_start = 1'b1; load_base = 6'd5; load_len = 7'd0;
        tick();
        check("len0 load_done", 32'(load_done), 1);
        check("len0 load_busy", 32'(load_busy), 0);
        tick();
        check("len0 done clears", 32'(load_done), 0);

        // Stalled burst: len 5 with 3 idle cycles, stray load_start ignored
        start_load(40, 5);
        write_word(16'h0300);
        write_word(16'h0301);
        for (int g = 0; g < 3; g++) begin
            if (g == 0) begin
                load_start = 1'b1; load_base = 6'd0; load_len = 7'd1;
            end
            tick();
            check("stall load_done", 32'(load_done), 0);
            check("stall load_busy", 32'(load_busy), 1);
        end
        for (int i = 2; i < 5; i++) begin
            write_word(16'h0300 + 16'(i));
            if (i < 4) check("stall early done", 32'(load_done), 0);
        end
        check("stall load_done", 32'(load_done), 1);
        tick();
        bank_swap = 1'b1;
        tick();
        act_m = 0;
        rd_issue(0, 40); rd_issue(1, 41); rd_issue(2, 42); rd_issue(3, 43);
        tick();
        rd_issue(0, 44); rd_issue(1, 45); rd_issue(2, 0);
        tick();

        // DEPTH=10: out-of-range read on port 2 beside in-range port 1
        t_load_start = 1'b1; t_load_base = 4'd3; t_load_len = 5'd1;
        tick();
        t_wr_valid = 1'b1; t_wr_data = 16'h0055;
        tick();
        check("d10 load_done", 32'(t_load_done), 1);
        tick();
        t_bank_swap = 1'b1;
        tick();
        check("d10 active_bank", 32'(t_active_bank), 1);
        check("d10 addr_err clear", 32'(t_addr_err), 0);
        t_rd_en = 4'b0110;
        t_rd_addr = {4'd0, 4'd12, 4'd3, 4'd0};
        tick();
        check("d10 rd_valid", 32'(t_rd_valid), 32'h6);
        check("d10 p1 data", 32'(t_rd_data[31:16]), 32'h55);
        check("d10 p2 zero", 32'(t_rd_data[47:32]), 0);
        check("d10 addr_err set", 32'(t_addr_err), 1);
        check("d64 addr_err", 32'(addr_err), 0);
        tick();
        tick();
        check("d10 addr_err sticky", 32'(t_addr_err), 1);
        check("d10 rd_valid idle", 32'(t_rd_valid), 0);
        check("d10 p1 hold", 32'(t_rd_data[31:16]), 32'h55);

        // Reset mid-burst
        bank_swap = 1'b1;
        tick();
        act_m = 1;
        check("pre-reset swap", 32'(active_bank), 1);
        start_load(0, 8);
        for (int i = 0; i < 3; i++) write_word(16'h0400 + 16'(i));
        #2;
        rst = 1'b1;
        #1;
        check("async rst active_bank", 32'(active_bank), 0);
        check("async rst load_busy", 32'(load_busy), 0);
        check("async rst wr_ready", 32'(wr_ready), 0);
        check("async rst load_done", 32'(load_done), 0);
        check("async rst rd_data", rd_data[31:0], 0);
        check("async rst rd_data hi", rd_data[63:32], 0);
        check("async rst d10 rd_data", t_rd_data[31:0], 0);
        check("async rst addr_err", 32'(t_addr_err), 0);
        clear_model();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst no done", 32'(load_done), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post-rst no done", 32'(load_done), 0);
            check("post-rst idle", 32'(load_busy), 0);
        end
        check("post-rst active_bank", 32'(active_bank), 0);
        rd_issue(0, 62); rd_issue(1, 0); rd_issue(2, 40);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
